// File: rtl/xdma_write_sched.sv
// xdma_write_sched: round-robin write-descriptor scheduler for the xDMA
// write meta manager. Descriptors from NumReq requesters are queued in a
// small FIFO and issued one at a time as registered meta plus a start pulse;
// each manager done pulse yields a completion back to the originating source.
// Optional build macro: XDMA_SCHED_STATS_EN enables the completion counter
// behind done_count_o (tied to zero otherwise).
module xdma_write_sched #(
    parameter int NumReq     = 2,
    parameter int IdWidth    = 8,
    parameter int LenWidth   = 16,
    parameter int QueueDepth = 4,
    localparam int SrcWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_valid_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  logic [NumReq*IdWidth-1:0]    req_id_i,
    input  logic [NumReq*LenWidth-1:0]   req_len_i,
    output logic [IdWidth-1:0]           meta_id_o,
    output logic [LenWidth-1:0]          meta_len_o,
    output logic                         start_o,
    input  logic                         done_i,
    output logic                         cpl_valid_o,
    output logic [SrcWidth-1:0]          cpl_src_o,
    output logic [IdWidth-1:0]           cpl_id_o,
    output logic [31:0]                  done_count_o
);

    localparam int AddrWidth = $clog2(QueueDepth);
    localparam int PtrWidth  = AddrWidth + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] BUSY  = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef struct packed {
        logic [SrcWidth-1:0] src;
        logic [IdWidth-1:0]  id;
        logic [LenWidth-1:0] len;
    } desc_t;

    logic [SrcWidth-1:0]  rr_q, rr_d;
    logic [NumReq-1:0]    grant;
    logic                 grant_any;
    desc_t                grant_desc;

    desc_t                mem_q [QueueDepth];
    desc_t                mem_d [QueueDepth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 fifo_full, fifo_empty, push, pop;
    desc_t                head;

    logic [2:0]           state_q, state_d;
    logic [IdWidth-1:0]   meta_id_q, meta_id_d;
    logic [LenWidth-1:0]  meta_len_q, meta_len_d;
    logic [SrcWidth-1:0]  src_q, src_d;

    // Round-robin pick: first valid at or above rr_q, else first valid below.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        grant      = '0;
        grant_any  = 1'b0;
        grant_desc = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!grant_any && req_valid_i[i] && (i >= int'(rr_q))) begin
                grant_any       = 1'b1;
                grant[i]        = 1'b1;
                grant_desc.src  = SrcWidth'(i);
                grant_desc.id   = req_id_i[i*IdWidth +: IdWidth];
                grant_desc.len  = req_len_i[i*LenWidth +: LenWidth];
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            if (!grant_any && req_valid_i[i]) begin
                grant_any       = 1'b1;
                grant[i]        = 1'b1;
                grant_desc.src  = SrcWidth'(i);
                grant_desc.id   = req_id_i[i*IdWidth +: IdWidth];
                grant_desc.len  = req_len_i[i*LenWidth +: LenWidth];
            end
        end
    end

    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]) &&
                         (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]);
    assign req_ready_o = grant & {NumReq{!fifo_full}};
    assign push        = grant_any && !fifo_full;
    assign pop         = (state_q == IDLE) && !fifo_empty;
    assign head        = mem_q[rd_ptr_q[AddrWidth-1:0]];

    // Next-state for arbiter pointer and FIFO storage/pointers.
    always_comb begin
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            rr_d = (int'(grant_desc.src) == NumReq - 1) ? '0
                                                        : grant_desc.src + SrcWidth'(1);
            mem_d[wr_ptr_q[AddrWidth-1:0]] = grant_desc;
            wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end
    end

    // Issue FSM: pop in IDLE, pulse start, wait for done, one-cycle completion.
    always_comb begin
        state_d    = state_q;
        meta_id_d  = meta_id_q;
        meta_len_d = meta_len_q;
        src_d      = src_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    meta_id_d  = head.id;
                    meta_len_d = head.len;
                    src_d      = head.src;
                    // A zero-length transfer would never finish in the manager.
                    state_d    = (head.len == '0) ? DONE : START;
                end
            end
            START:     state_d = BUSY;
            BUSY:      if (done_i) state_d = GAP;
            GAP, DONE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Control and meta registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_ni) begin
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= IDLE;
            meta_id_q  <= '0;
            meta_len_q <= '0;
            src_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            meta_id_q  <= meta_id_d;
            meta_len_q <= meta_len_d;
            src_q      <= src_d;
        end
    end

    // Descriptor storage.
    // NOTE: no reset on the storage array; entries are only read when the pointers mark them valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign start_o     = (state_q == START);
    assign cpl_valid_o = (state_q == GAP) || (state_q == DONE);
    assign cpl_src_o   = src_q;
    assign cpl_id_o    = meta_id_q;
    assign meta_id_o   = meta_id_q;
    assign meta_len_o  = meta_len_q;

`ifdef XDMA_SCHED_STATS_EN
    logic [31:0] done_count_q, done_count_d;

    // Completion counter, wraps naturally at 2^32.
    always_comb begin
        done_count_d = done_count_q + {31'd0, cpl_valid_o};
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_count_q <= '0;
        end else begin
            done_count_q <= done_count_d;
        end
    end

    assign done_count_o = done_count_q;
`else
    assign done_count_o = '0;
`endif

endmodule

// File: tb/tb_xdma_write_sched.sv
// tb_xdma_write_sched: directed bench for xdma_write_sched (default params).
// A cycle table covers round-robin grants and FIFO-full backpressure; short
// hand-written sequences cover latency, zero-length, spurious done and reset.
module tb_xdma_write_sched;

    localparam int NumReq     = 2;
    localparam int IdWidth    = 8;
    localparam int LenWidth   = 16;
    localparam int QueueDepth = 4;
    localparam int SrcWidth   = 1;

`ifdef XDMA_SCHED_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic                 clk_i;
    logic                 rst_ni;
    logic [NumReq-1:0]    req_valid_i;
    logic [NumReq-1:0]    req_ready_o;
    logic [IdWidth-1:0]   id0, id1;
    logic [LenWidth-1:0]  len0, len1;
    logic [IdWidth-1:0]   meta_id_o;
    logic [LenWidth-1:0]  meta_len_o;
    logic                 start_o;
    logic                 done_i;
    logic                 cpl_valid_o;
    logic [SrcWidth-1:0]  cpl_src_o;
    logic [IdWidth-1:0]   cpl_id_o;
    logic [31:0]          done_count_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    xdma_write_sched #(
        .NumReq     (NumReq),
        .IdWidth    (IdWidth),
        .LenWidth   (LenWidth),
        .QueueDepth (QueueDepth)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_id_i     ({id1, id0}),
        .req_len_i    ({len1, len0}),
        .meta_id_o    (meta_id_o),
        .meta_len_o   (meta_len_o),
        .start_o      (start_o),
        .done_i       (done_i),
        .cpl_valid_o  (cpl_valid_o),
        .cpl_src_o    (cpl_src_o),
        .cpl_id_o     (cpl_id_o),
        .done_count_o (done_count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
        return StatsEn ? 32'(exp_cnt) : 32'd0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"},    32'(start_o),      0);
        check({tag, "_cpl"},      32'(cpl_valid_o),  0);
        check({tag, "_cpl_src"},  32'(cpl_src_o),    0);
        check({tag, "_cpl_id"},   32'(cpl_id_o),     0);
        check({tag, "_meta_id"},  32'(meta_id_o),    0);
        check({tag, "_meta_len"}, 32'(meta_len_o),   0);
        check({tag, "_count"},    done_count_o,      0);
    endtask

    // Called at the negedge of a START cycle: manager answers 'beats' cycles
    // later, then done is also pulsed in GAP and IDLE to prove it is ignored.
    task automatic finish_after(input int beats, input int src, input int id, input int len);
        for (int b = 1; b <= beats; b++) begin
            @(negedge clk_i);
            done_i = (b == beats);
            #1;
            check("busy_start",    32'(start_o),     0);
            check("busy_cpl",      32'(cpl_valid_o), 0);
            check("busy_meta_id",  32'(meta_id_o),   32'(id));
            check("busy_meta_len", 32'(meta_len_o),  32'(len));
        end
        @(negedge clk_i);
        done_i = 1'b1;
        #1;
        check("gap_cpl",      32'(cpl_valid_o), 1);
        check("gap_cpl_src",  32'(cpl_src_o),   32'(src));
        check("gap_cpl_id",   32'(cpl_id_o),    32'(id));
        check("gap_start",    32'(start_o),     0);
        check("gap_meta_len", 32'(meta_len_o),  32'(len));
        exp_cnt++;
        @(negedge clk_i);
        done_i = 1'b1;
        #1;
        check("idle_cpl",   32'(cpl_valid_o), 0);
        check("idle_start", 32'(start_o),     0);
        @(negedge clk_i);
        done_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0] valid;
        logic       done;
        logic [1:0] rdy;
        logic       st;
        logic       cpl;
        logic [7:0] meta;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // Cycle table from reset: req0 id 1, req1 id 2, len 3, both always valid.
        tbl[0]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{2'b11, 1'b0, 2'b10, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{2'b11, 1'b0, 2'b01, 1'b1, 1'b0, 8'h01};
        tbl[3]  = '{2'b11, 1'b0, 2'b10, 1'b0, 1'b0, 8'h01};
        tbl[4]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0, 8'h01};
        tbl[5]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 8'h01};
        tbl[6]  = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 8'h01};
        tbl[7]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 8'h01};
        tbl[8]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 8'h01};
        tbl[9]  = '{2'b11, 1'b0, 2'b10, 1'b1, 1'b0, 8'h02};
        tbl[10] = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 8'h02};

        rst_ni      = 1'b1;
        req_valid_i = '0;
        done_i      = 1'b0;
        id0 = 8'h01; id1 = 8'h02; len0 = 16'd3; len1 = 16'd3;
        #1 rst_ni = 1'b0;

        // Reset state and combinational grant.
        @(negedge clk_i);
        #1;
        check_reset_outputs("rst");
        req_valid_i = 2'b11;
        #1 check("rst_ready_both", 32'(req_ready_o), 'h1);
        req_valid_i = 2'b10;
        #1 check("rst_ready_req1", 32'(req_ready_o), 'h2);
        req_valid_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Round-robin and FIFO-full table.
        for (int i = 0; i < 11; i++) begin
            req_valid_i = tbl[i].valid;
            done_i      = tbl[i].done;
            #1;
            check($sformatf("tbl%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].rdy));
            check($sformatf("tbl%0d_start", i), 32'(start_o),     32'(tbl[i].st));
            check($sformatf("tbl%0d_cpl", i),   32'(cpl_valid_o), 32'(tbl[i].cpl));
            check($sformatf("tbl%0d_meta", i),  32'(meta_id_o),   32'(tbl[i].meta));
            if (tbl[i].cpl) begin
                check($sformatf("tbl%0d_cpl_id", i), 32'(cpl_id_o), 32'(tbl[i].meta));
                exp_cnt++;
            end
            @(negedge clk_i);
        end
        req_valid_i = '0;
        done_i      = 1'b0;

        // Drain two more in FIFO order: id2 (req1) is active, then id1 (req0).
        finish_after(1, 1, 'h02, 3);
        #1;
        check("drain1_start", 32'(start_o),   1);
        check("drain1_meta",  32'(meta_id_o), 'h01);
        finish_after(2, 0, 'h01, 3);
        #1;
        check("drain2_start", 32'(start_o),   1);
        check("drain2_meta",  32'(meta_id_o), 'h02);
        check("drain_count",  done_count_o,   exp_count());

        // Reset while BUSY with two entries still queued.
        @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        exp_cnt = 0;
        check_reset_outputs("midrst");
        req_valid_i = 2'b11;
        #1 check("midrst_ready", 32'(req_ready_o), 'h1);
        req_valid_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            check("postrst_start", 32'(start_o),     0);
            check("postrst_cpl",   32'(cpl_valid_o), 0);
        end

        // Single descriptor: start at accept+2, meta stable until completion.
        id0 = 8'h12; len0 = 16'd4;
        req_valid_i = 2'b01;
        #1 check("single_ready", 32'(req_ready_o), 'h1);
        @(negedge clk_i);
        req_valid_i = '0;
        #1 check("single_start_n1", 32'(start_o), 0);
        @(negedge clk_i);
        #1;
        check("single_start_n2", 32'(start_o),    1);
        check("single_meta_id",  32'(meta_id_o),  'h12);
        check("single_meta_len", 32'(meta_len_o), 4);
        finish_after(4, 0, 'h12, 4);
        #1;
        check("spurious_start", 32'(start_o),     0);
        check("spurious_cpl",   32'(cpl_valid_o), 0);
        @(negedge clk_i);
        #1;
        check("spurious_start2", 32'(start_o),     0);
        check("spurious_cpl2",   32'(cpl_valid_o), 0);

        // Zero-length then a len=3 descriptor from req1.
        id0 = 8'h07; len0 = 16'd0;
        req_valid_i = 2'b01;
        #1 check("zero_ready", 32'(req_ready_o), 'h1);
        @(negedge clk_i);
        id1 = 8'h33; len1 = 16'd3;
        req_valid_i = 2'b10;
        #1;
        check("zero_ready_req1", 32'(req_ready_o), 'h2);
        check("zero_start_n1",   32'(start_o),     0);
        check("zero_cpl_n1",     32'(cpl_valid_o), 0);
        @(negedge clk_i);
        req_valid_i = '0;
        #1;
        check("zero_cpl",     32'(cpl_valid_o), 1);
        check("zero_cpl_id",  32'(cpl_id_o),    'h07);
        check("zero_cpl_src", 32'(cpl_src_o),   0);
        check("zero_start",   32'(start_o),     0);
        exp_cnt++;
        @(negedge clk_i);
        #1;
        check("after_zero_start", 32'(start_o),     0);
        check("after_zero_cpl",   32'(cpl_valid_o), 0);
        @(negedge clk_i);
        #1;
        check("len3_start",    32'(start_o),    1);
        check("len3_meta_id",  32'(meta_id_o),  'h33);
        check("len3_meta_len", 32'(meta_len_o), 3);
        finish_after(3, 1, 'h33, 3);
        #1;
        check("final_count", done_count_o, exp_count());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
